// File: rtl/hazard3_instr_aligner_pkg.sv
// Shared types and helpers for the hazard3 halfword instruction aligner.
// Halfword buffer is kept LSB-aligned; bits above its level are always zero.
package hazard3_instr_aligner_pkg;

  localparam int HW_W     = 16;
  localparam int CIR_W    = 32;
  localparam int HWBUF_HW = 3;
  localparam int HWBUF_W  = HW_W * HWBUF_HW;

  typedef enum logic [1:0] {
    USE_NONE = 2'd0,
    USE_ONE  = 2'd1,
    USE_TWO  = 2'd2,
    USE_BAD  = 2'd3
  } cir_use_e;

  typedef struct packed {
    logic        drop_low;
    logic [31:0] word;
  } fetch_ent_t;

  typedef struct packed {
    logic [HWBUF_W-1:0] data;
    logic [1:0]         level;
  } hwbuf_t;

  function automatic hwbuf_t hwbuf_retire(input hwbuf_t cur, input logic [1:0] use_hw);
    hwbuf_t r;
    r = cur;
    case (use_hw)
      USE_ONE: begin
        r.data  = {16'h0000, cur.data[47:16]};
        r.level = cur.level - 2'd1;
      end
      USE_TWO: begin
        r.data  = {32'h0000_0000, cur.data[47:32]};
        r.level = cur.level - 2'd2;
      end
      default: r = cur;
    endcase
    return r;
  endfunction

  // Appends a fetch word above the live halfwords; drop-low keeps only the upper half.
  function automatic hwbuf_t hwbuf_append(input hwbuf_t cur, input fetch_ent_t ent);
    hwbuf_t      r;
    logic [31:0] app;
    logic [1:0]  n;
    if (ent.drop_low) begin
      app = {16'h0000, ent.word[31:16]};
      n   = 2'd1;
    end else begin
      app = ent.word;
      n   = 2'd2;
    end
    r = cur;
    case (cur.level)
      2'd0: begin
        r.data  = {16'h0000, app};
        r.level = n;
      end
      2'd1: begin
        r.data  = {app, cur.data[15:0]};
        r.level = 2'd1 + n;
      end
      default: r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard3_instr_aligner_chk.sv
// Illegal-input checks for the aligner; instantiated only under HAZARD3_ASSERTIONS.
module hazard3_instr_aligner_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] cir_use_i,
  input logic [1:0] cir_vld_i,
  input logic       cir_lock_i,
  input logic       push_i,
  input logic       pop_i,
  input logic       fifo_full_i,
  input logic       fifo_empty_i,
  input logic [1:0] hw_level_i
);

  a_use_le_vld: assert property (@(posedge clk) disable iff (!rst_n) cir_use_i <= cir_vld_i);
  a_use_not3:   assert property (@(posedge clk) disable iff (!rst_n) cir_use_i != 2'd3);
  a_lock_use:   assert property (@(posedge clk) disable iff (!rst_n) !(cir_lock_i && cir_use_i != 2'd0));
  a_no_ovf:     assert property (@(posedge clk) disable iff (!rst_n) !(push_i && fifo_full_i && !pop_i));
  a_no_udf:     assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && fifo_empty_i));
  a_level_max:  assert property (@(posedge clk) disable iff (!rst_n) hw_level_i <= 2'd3);

endmodule

// File: rtl/hazard3_instr_aligner_fifo.sv
// Fetch-word FIFO (word + drop-low flag) with push/pop/flush and occupancy.
module hazard3_instr_aligner_fifo
  import hazard3_instr_aligner_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  fetch_ent_t push_data_i,
  input  logic       pop_i,
  output fetch_ent_t head_o,
  output logic [2:0] level_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_ent_t      mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [2:0]      level_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  // Pointer, occupancy and storage update; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= 3'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 3'd1;
        2'b01:   level_q <= level_q - 3'd1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == 3'(DEPTH));
  assign empty_o = (level_q == 3'd0);

endmodule

// File: rtl/hazard3_instr_aligner.sv
// Halfword aligner: fetch FIFO feeding a 3-halfword buffer that forms the CIR.
// Optional HAZARD3_ALIGNER_BYPASS_EN lets a fetch word skip an empty FIFO.
module hazard3_instr_aligner
  import hazard3_instr_aligner_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_wdata_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic        jump_now_i,
  input  logic        jump_target_hw_i,
  output logic [31:0] cir_o,
  output logic [1:0]  cir_vld_o,
  input  logic [1:0]  cir_use_i,
  input  logic        cir_lock_i,
  output logic [2:0]  fifo_level_o
);

  logic [HWBUF_W-1:0] hwbuf_q, hwbuf_d;
  logic [1:0]         hw_level_q, hw_level_d;
  logic               unaligned_pend_q, unaligned_pend_d;

  logic       accept_s, push_s, pop_s, bypass_s;
  logic [2:0] fifo_level_s;
  logic       fifo_full_s, fifo_empty_s;
  fetch_ent_t fifo_head_s, push_ent_s;
  hwbuf_t     cur_s, used_s, popped_s, nxt_s;

  hazard3_instr_aligner_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (jump_now_i),
    .push_i      (push_s),
    .push_data_i (push_ent_s),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .level_o     (fifo_level_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // Retire, refill from FIFO, optionally bypass, and track the drop-low flag.
  always_comb begin
    cur_s.data       = hwbuf_q;
    cur_s.level      = hw_level_q;
    accept_s         = fetch_valid_i & fetch_ready_o;
    push_ent_s.drop_low = unaligned_pend_q;
    push_ent_s.word  = fetch_wdata_i;
    pop_s            = 1'b0;
    bypass_s         = 1'b0;
    used_s           = hwbuf_retire(cur_s, cir_lock_i ? USE_NONE : cir_use_i);
    popped_s         = used_s;
    if (!jump_now_i && !cir_lock_i && (used_s.level <= 2'd1) && !fifo_empty_s) begin
      pop_s    = 1'b1;
      popped_s = hwbuf_append(used_s, fifo_head_s);
    end else begin
      popped_s = used_s;
    end
    nxt_s = popped_s;
`ifdef HAZARD3_ALIGNER_BYPASS_EN
    // The level check on the post-pop state guarantees the bypassed word fits.
    if (accept_s && !jump_now_i && !cir_lock_i && (popped_s.level <= 2'd1) &&
        (fifo_empty_s || (pop_s && (fifo_level_s == 3'd1)))) begin
      bypass_s = 1'b1;
      nxt_s    = hwbuf_append(popped_s, push_ent_s);
    end else begin
      bypass_s = 1'b0;
    end
`endif
    push_s = accept_s & ~jump_now_i & ~bypass_s;
    if (jump_now_i) begin
      hwbuf_d          = '0;
      hw_level_d       = 2'd0;
      unaligned_pend_d = jump_target_hw_i;
    end else begin
      hwbuf_d          = nxt_s.data;
      hw_level_d       = nxt_s.level;
      unaligned_pend_d = accept_s ? 1'b0 : unaligned_pend_q;
    end
  end

  // Halfword buffer and alignment state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwbuf_q          <= '0;
      hw_level_q       <= 2'd0;
      unaligned_pend_q <= 1'b0;
    end else begin
      hwbuf_q          <= hwbuf_d;
      hw_level_q       <= hw_level_d;
      unaligned_pend_q <= unaligned_pend_d;
    end
  end

  assign cir_o         = hwbuf_q[CIR_W-1:0];
  assign cir_vld_o     = (hw_level_q == 2'd3) ? 2'd2 : hw_level_q;
  assign fetch_ready_o = ~fifo_full_s;
  assign fifo_level_o  = fifo_level_s;

`ifdef HAZARD3_ASSERTIONS
  hazard3_instr_aligner_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .cir_use_i    (cir_use_i),
    .cir_vld_i    (cir_vld_o),
    .cir_lock_i   (cir_lock_i),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .fifo_full_i  (fifo_full_s),
    .fifo_empty_i (fifo_empty_s),
    .hw_level_i   (hw_level_q)
  );
`endif

endmodule

// File: tb/tb_hazard3_instr_aligner.sv
// Directed bench for hazard3_instr_aligner (default build, FIFO_DEPTH=2).
module tb_hazard3_instr_aligner;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_wdata;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        jump_now;
  logic        jump_target_hw;
  logic [31:0] cir;
  logic [1:0]  cir_vld;
  logic [1:0]  cir_use;
  logic        cir_lock;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_errors = 0;

  hazard3_instr_aligner #(.FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_wdata_i    (fetch_wdata),
    .fetch_valid_i    (fetch_valid),
    .fetch_ready_o    (fetch_ready),
    .jump_now_i       (jump_now),
    .jump_target_hw_i (jump_target_hw),
    .cir_o            (cir),
    .cir_vld_o        (cir_vld),
    .cir_use_i        (cir_use),
    .cir_lock_i       (cir_lock),
    .fifo_level_o     (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle 1ns past the edge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic [1:0] u,
                     input logic lk, input logic jp, input logic tg);
    fetch_valid    = v;
    fetch_wdata    = w;
    cir_use        = u;
    cir_lock       = lk;
    jump_now       = jp;
    jump_target_hw = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cir(input string tag, input logic [31:0] exp_cir, input logic [1:0] exp_vld);
    check_val({tag, "_cir"}, cir, exp_cir);
    check_val({tag, "_vld"}, {30'd0, cir_vld}, {30'd0, exp_vld});
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0; fetch_wdata = 32'h0; cir_use = 2'd0;
    cir_lock = 1'b0; jump_now = 1'b0; jump_target_hw = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk_cir("reset", 32'h0000_0000, 2'd0);
    check_val("reset_ready", {31'd0, fetch_ready}, 32'd1);
    check_val("reset_lvl", {29'd0, fifo_level}, 32'd0);

    // Aligned stream, one cycle of fifo latency
    cyc(1'b1, 32'h0013_0013, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("al_k", 32'h0000_0000, 2'd0);
    check_val("al_k_lvl", {29'd0, fifo_level}, 32'd1);
    cyc(1'b1, 32'h0023_0023, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("al_k1", 32'h0013_0013, 2'd2);
    check_val("al_k1_lvl", {29'd0, fifo_level}, 32'd1);
    cyc(1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    chk_cir("al_w2", 32'h0023_0023, 2'd2);
    check_val("al_w2_lvl", {29'd0, fifo_level}, 32'd0);
    cyc(1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    chk_cir("al_empty", 32'h0000_0000, 2'd0);

    // Jump to upper halfword: low half of first word is dropped
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1);
    chk_cir("jmp", 32'h0000_0000, 2'd0);
    cyc(1'b1, 32'hAAAA_4501, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("jmp_acc", 32'h0000_0000, 2'd0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("jmp_hi", 32'h0000_AAAA, 2'd1);
    cyc(1'b1, 32'h1234_5678, 2'd1, 1'b0, 1'b0, 1'b0);
    chk_cir("jmp_use", 32'h0000_0000, 2'd0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("jmp_next_full", 32'h1234_5678, 2'd2);
    cyc(1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    chk_cir("jmp_drain", 32'h0000_0000, 2'd0);

    // Compressed stream retiring one halfword per cycle
    cyc(1'b1, 32'h4501_4485, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("c16_a", {16'd0, cir[15:0]}, 32'h0000_4485);
    cyc(1'b0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
    chk_cir("c16_b", 32'h0000_4501, 2'd1);
    cyc(1'b0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
    chk_cir("c16_end", 32'h0000_0000, 2'd0);

    // Mixed: a 32-bit instruction spanning two fetch words
    cyc(1'b1, 32'h0013_4485, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4501_0000, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("mix_a", 32'h0013_4485, 2'd2);
    cyc(1'b0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
    chk_cir("mix_span", 32'h0000_0013, 2'd2);
    cyc(1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    chk_cir("mix_tail", 32'h0000_4501, 2'd1);
    check_val("mix_lvl", {29'd0, fifo_level}, 32'd0);
    cyc(1'b0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
    chk_cir("mix_end", 32'h0000_0000, 2'd0);

    // cir_lock: window frozen while fifo fills to full
    cyc(1'b1, 32'h1111_2222, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("lk_pre", 32'h1111_2222, 2'd2);
    cyc(1'b1, 32'hA000_0001, 2'd0, 1'b1, 1'b0, 1'b0);
    check_val("lk_lvl1", {29'd0, fifo_level}, 32'd1);
    cyc(1'b1, 32'hA000_0002, 2'd0, 1'b1, 1'b0, 1'b0);
    check_val("lk_full_lvl", {29'd0, fifo_level}, 32'd2);
    check_val("lk_full_rdy", {31'd0, fetch_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'hBAD0_0000, 2'd0, 1'b1, 1'b0, 1'b0);
      chk_cir("lk_hold", 32'h1111_2222, 2'd2);
    end
    cyc(1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    chk_cir("lk_rel1", 32'hA000_0001, 2'd2);
    check_val("lk_rel_rdy", {31'd0, fetch_ready}, 32'd1);
    cyc(1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    chk_cir("lk_rel2", 32'hA000_0002, 2'd2);
    cyc(1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    chk_cir("lk_end", 32'h0000_0000, 2'd0);
    check_val("lk_end_lvl", {29'd0, fifo_level}, 32'd0);

    // Jump with a full fifo and a coincident fetch word
    cyc(1'b1, 32'hC000_0001, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC000_0002, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC000_0003, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("jf_full", {29'd0, fifo_level}, 32'd2);
    cyc(1'b1, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b1, 1'b0);
    chk_cir("jf_clr", 32'h0000_0000, 2'd0);
    check_val("jf_lvl", {29'd0, fifo_level}, 32'd0);
    check_val("jf_rdy", {31'd0, fetch_ready}, 32'd1);
    cyc(1'b1, 32'h1357_2468, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("jf_next", 32'h1357_2468, 2'd2);

    // Jump while ready: the coincident accepted word is discarded
    cyc(1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_cir("jr_disc", 32'h0000_0000, 2'd0);
    check_val("jr_lvl", {29'd0, fifo_level}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
